// File: rtl/rv32i_enc_pkg.sv
// ============================================================================
// Module   : rv32i_enc_pkg
// Purpose  : Shared format, error and opcode codes for the RV32I encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT      = 2'd3;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_fields_t;

    // True when imm[31:msb] are all copies of the same bit (value fits signed).
    function automatic logic upper_uniform(input logic [31:0] imm, input logic [4:0] msb);
        logic [31:0] sh;
        sh = $unsigned($signed(imm) >>> msb);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_imm_pack.sv
// ============================================================================
// Module   : rv32i_imm_pack
// Purpose  : Combinational RV32I field packer with immediate legality checks.
//            Range/alignment checks enabled by RV32I_ENC_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_imm_pack
    import rv32i_enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  enc_fields_t fields_i,
    output logic [31:0] instr_o,
    output logic [1:0]  err_o
);

    logic [31:0] w_imm;
    logic [31:0] w_word;
    logic        w_fmt_bad;
    logic [1:0]  w_chk;

    assign w_imm = fields_i.imm;

    always_comb begin
        w_word    = '0;
        w_fmt_bad = 1'b0;
        case (fields_i.fmt)
            FMT_R: w_word = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                             fields_i.funct3, fields_i.rd, fields_i.opcode};
            FMT_I: w_word = {w_imm[11:0], fields_i.rs1, fields_i.funct3,
                             fields_i.rd, fields_i.opcode};
            FMT_S: w_word = {w_imm[11:5], fields_i.rs2, fields_i.rs1,
                             fields_i.funct3, w_imm[4:0], fields_i.opcode};
            FMT_B: w_word = {w_imm[12], w_imm[10:5], fields_i.rs2, fields_i.rs1,
                             fields_i.funct3, w_imm[4:1], w_imm[11], fields_i.opcode};
            FMT_U: w_word = {w_imm[31:12], fields_i.rd, fields_i.opcode};
            FMT_J: w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                             fields_i.rd, fields_i.opcode};
            default: w_fmt_bad = 1'b1;
        endcase
    end

`ifdef RV32I_ENC_RANGE_CHECK_EN
    always_comb begin
        w_chk = ERR_NONE;
        case (fields_i.fmt)
            FMT_I, FMT_S: if (!upper_uniform(w_imm, 5'd11)) w_chk = ERR_RANGE;
            FMT_B: begin
                if (w_imm[0])                          w_chk = ERR_MISALIGN;
                else if (!upper_uniform(w_imm, 5'd12)) w_chk = ERR_RANGE;
            end
            FMT_J: begin
                if (w_imm[0])                          w_chk = ERR_MISALIGN;
                else if (!upper_uniform(w_imm, 5'd20)) w_chk = ERR_RANGE;
            end
            FMT_U: if (w_imm[11:0] != 12'd0) w_chk = ERR_RANGE;
            default: w_chk = ERR_NONE;
        endcase
    end
`else
    // Without checks the packer silently keeps only the bits each format encodes.
    assign w_chk = ERR_NONE;
`endif

    assign err_o   = w_fmt_bad ? ERR_FMT : w_chk;
    assign instr_o = (err_o != ERR_NONE) ? NOP_WORD : w_word;

endmodule

`default_nettype wire

// File: rtl/rv32i_instr_encoder.sv
// ============================================================================
// Module   : rv32i_instr_encoder
// Purpose  : Two-stage valid/ready pipeline packing decoded fields into RV32I
//            words. Optional checks: RV32I_ENC_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  in_fmt_i,
    input  logic [6:0]  in_opcode_i,
    input  logic [4:0]  in_rd_i,
    input  logic [4:0]  in_rs1_i,
    input  logic [4:0]  in_rs2_i,
    input  logic [2:0]  in_funct3_i,
    input  logic [6:0]  in_funct7_i,
    input  logic [31:0] in_imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [1:0]  out_err_o
);

    logic        s1_valid_q, s1_valid_d;
    enc_fields_t s1_fields_q, s1_fields_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic [1:0]  s2_err_q, s2_err_d;

    enc_fields_t w_in_fields;
    logic [31:0] w_instr;
    logic [1:0]  w_err;
    logic        w_s2_load;
    logic        w_s1_load;

    assign w_in_fields = '{fmt: in_fmt_i, opcode: in_opcode_i, rd: in_rd_i,
                           rs1: in_rs1_i, rs2: in_rs2_i, funct3: in_funct3_i,
                           funct7: in_funct7_i, imm: in_imm_i};

    rv32i_imm_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .fields_i (s1_fields_q),
        .instr_o  (w_instr),
        .err_o    (w_err)
    );

    // Loading on drain lets a full pipeline accept a new beat in the same cycle.
    assign w_s2_load  = !s2_valid_q || out_ready_i;
    assign w_s1_load  = !s1_valid_q || w_s2_load;
    assign in_ready_o = w_s1_load;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = w_instr;
                s2_err_d   = w_err;
            end
        end
        if (w_s1_load) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) s1_fields_d = w_in_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= ERR_NONE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_instr_o = s2_instr_q;
    assign out_err_o   = s2_err_q;

endmodule

`default_nettype wire

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the core's immediate generator: packs decoded fields (format, opcode, registers, funct, 32-bit immediate) back into a 32-bit RV32I instruction word.
- Used by the self-test instruction injector and by the verification stimulus path to build encodings in hardware.
- Two-stage valid/ready pipeline with backpressure.
- Flags immediates that do not fit the format or are misaligned.

Parameters:
- NOP_WORD, 32'h0000_0013, word emitted in place of an errored instruction (ADDI x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept a beat
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode field
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  immediate value, sign-extended byte offset
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_instr  out  32  encoded instruction
- out_err  out  2  0=ok 1=range 2=misaligned 3=bad format

Behaviour:
- Reset (asynchronous, rst_n low) clears both stage valids.
- Reset values: out_valid=0, out_instr=0, out_err=0. in_ready=1 the first cycle after reset release.
- Handshake:
  - A beat transfers on in_valid&&in_ready. Output transfers on out_valid&&out_ready.
  - out_* hold stable while out_valid&&!out_ready.
- Pipeline:
  - S1 registers the fields and computes error flags.
  - S2 registers the packed word.
  - Latency is exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Stall rules:
  - S2 loads when it is empty or is draining this cycle.
  - S1 loads when S1 is empty or moving to S2.
  - in_ready = !S1_valid || S1_advance. This is combinational from out_ready, with no bubble on simultaneous drain+fill.
  - Two beats are held with out_ready low. The third is refused (in_ready=0) and no beat is ever dropped or reordered.
- Packing (bit ranges inclusive):
  - R = {funct7,rs2,rs1,f3,rd,op}
  - I = {imm[11:0],rs1,f3,rd,op}
  - S = {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B = {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U = {imm[31:12],rd,op}
  - J = {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never an error.
- Error priority: bad format(3) > misaligned(2) > range(1).
- Any error forces out_instr=NOP_WORD, and the beat is still delivered in order.
- Reset mid-operation discards in-flight beats. No output beat appears for them.

Optional Feature:
- Macro: RV32I_ENC_RANGE_CHECK_EN.
- Defined: range and misalignment checks as above.
- Undefined:
  - Only bad format is reported.
  - Immediates are truncated silently to the field bits.
  - Odd B/J offsets drop bit0.
  - Error codes 1/2 never appear.
  - The timing path through S1 shortens.

Decomposition:
- Package rv32i_enc_pkg holds:
  - format codes FMT_R..FMT_J
  - error codes ERR_NONE/ERR_RANGE/ERR_MISALIGN/ERR_FMT
  - opcode constants (OP_IMM=7'h13, LUI=7'h37, JAL=7'h6F, BRANCH=7'h63, STORE=7'h23, OP=7'h33)
- One sub-module, rv32i_imm_pack: purely combinational field packer plus check logic, instantiated in S1/S2. The top keeps only pipeline and handshake state.

Test Plan:
- I-format: fmt=1, op=13, rd=1, rs1=2, f3=0, imm=FFFFFFFF -> out_instr=FFF10093, err=0, out_valid 2 cycles after accept.
- B/J: B op=63, rs1=rs2=0, imm=FFFFFFFC -> FE000EE3. Then J op=6F, rd=1, imm=00000800 -> 001000EF.
- U and errors:
  - U op=37, rd=5, imm=12345000 -> 123452B7.
  - B imm=3 -> err=2, instr=00000013.
  - I imm=800 -> err=1.
  - fmt=7 -> err=3.
- Backpressure: hold out_ready=0, offer 3 beats -> in_ready falls after 2. Release -> 3 beats out in order, out_* stable while stalled.
- Streaming: out_ready=1, 16 back-to-back beats -> 16 outputs on consecutive cycles, no bubbles.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale beat emerges.
